// File: rtl/rx_zc_corr.sv
// rtl/rx_zc_corr.sv - ZC reference conjugate correlator with LS estimate stream
// Reference samples queue in a small FIFO and are paired in order with received samples.
module rx_zc_corr #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int ACC_WIDTH  = 37
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [11:0]             zc_len,
    input  logic                    start,
    input  logic                    ref_valid,
    input  logic [2*DATA_WIDTH-1:0] ref_data,
    output logic                    ref_ready,
    input  logic                    rx_valid,
    input  logic [2*DATA_WIDTH-1:0] rx_data,
    output logic                    busy,
    output logic                    done,
    output logic                    est_valid,
    output logic [31:0]             est_data,
    output logic                    corr_valid,
    output logic [2*ACC_WIDTH-1:0]  corr_data,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                 state_q;
    logic [11:0]            len_q, cnt_q;
    logic [AW:0]            wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, wr_base;
    logic [PW-1:0]          mem_q [FIFO_DEPTH];
    logic                   busy_q, done_q, ovf_q, udf_q;
    logic [2*ACC_WIDTH-1:0] corr_q;

    logic                   s1_v_q, s2_v_q, est_v_q;
    logic [PW-1:0]          s1_r_q, s1_c_q;
    logic signed [PW-1:0]   p_ii_q, p_qq_q, p_qi_q, p_iq_q;
    logic [31:0]            est_q;
    logic [ACC_WIDTH-1:0]   acc_i_q, acc_q_q;

    logic                   start_acc, fifo_empty, fifo_full, wr_en, pop;
    logic signed [PW-1:0]   r_i, r_q, c_i, c_q;
    logic signed [SW-1:0]   sum_i, sum_q, rnd_i, rnd_q, sh_i, sh_q;

    function automatic logic [15:0] sat16(input logic [SW-1:0] v);
        logic [15:0] r;
        if (v[SW-1:15] == {(SW-15){1'b0}} || v[SW-1:15] == {(SW-15){1'b1}})
            r = v[15:0];
        else
            r = v[SW-1] ? 16'h8000 : 16'h7fff;
        return r;
    endfunction

    // An accepted start flushes the FIFO; a same-cycle reference lands in the emptied slot 0.
    always_comb begin
        start_acc  = (state_q == S_IDLE) && start && (zc_len != 12'd0);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        ref_ready  = ((state_q == S_RUN) || start_acc) && !fifo_full;
        wr_en      = ref_valid && ref_ready;
        pop        = (state_q == S_RUN) && rx_valid && !fifo_empty;
        wr_base    = start_acc ? '0 : wr_ptr_q;
        wr_ptr_d   = wr_base + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = start_acc ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem_q[wr_base[AW-1:0]] <= ref_data;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            corr_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= 1'b0;
            if (start_acc) begin
                len_q  <= zc_len;
                cnt_q  <= '0;
                corr_q <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_q + {11'd0, pop};
                if (state_q == S_RUN && ref_valid && !ref_ready)
                    ovf_q <= 1'b1;
                if (state_q == S_RUN && rx_valid && fifo_empty)
                    udf_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (start_acc) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
                S_RUN: if (pop && (cnt_q + 12'd1 == len_q))
                    state_q <= S_FLUSH;
                S_FLUSH: if (!s1_v_q && !s2_v_q) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    corr_q  <= {acc_i_q, acc_q_q};
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operands are widened to product width so the multiply keeps all bits.
    assign r_i = {{DATA_WIDTH{s1_r_q[PW-1]}}, s1_r_q[PW-1:DATA_WIDTH]};
    assign r_q = {{DATA_WIDTH{s1_r_q[DATA_WIDTH-1]}}, s1_r_q[DATA_WIDTH-1:0]};
    assign c_i = {{DATA_WIDTH{s1_c_q[PW-1]}}, s1_c_q[PW-1:DATA_WIDTH]};
    assign c_q = {{DATA_WIDTH{s1_c_q[DATA_WIDTH-1]}}, s1_c_q[DATA_WIDTH-1:0]};

    always_comb begin
        sum_i = {p_ii_q[PW-1], p_ii_q} + {p_qq_q[PW-1], p_qq_q};
        sum_q = {p_qi_q[PW-1], p_qi_q} - {p_iq_q[PW-1], p_iq_q};
        rnd_i = sum_i + SW'(16);
        rnd_q = sum_q + SW'(16);
        sh_i  = rnd_i >>> 5;
        sh_q  = rnd_q >>> 5;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            est_v_q <= 1'b0;
            s1_r_q  <= '0;
            s1_c_q  <= '0;
            p_ii_q  <= '0;
            p_qq_q  <= '0;
            p_qi_q  <= '0;
            p_iq_q  <= '0;
            est_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            s1_v_q  <= pop;
            s2_v_q  <= s1_v_q;
            est_v_q <= s2_v_q;
            if (pop) begin
                s1_r_q <= rx_data;
                s1_c_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
            if (s1_v_q) begin
                p_ii_q <= r_i * c_i;
                p_qq_q <= r_q * c_q;
                p_qi_q <= r_q * c_i;
                p_iq_q <= r_i * c_q;
            end
            if (s2_v_q)
                est_q <= {sat16(sh_i), sat16(sh_q)};
            if (start_acc) begin
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (s2_v_q) begin
                acc_i_q <= acc_i_q + {{(ACC_WIDTH-SW){sum_i[SW-1]}}, sum_i};
                acc_q_q <= acc_q_q + {{(ACC_WIDTH-SW){sum_q[SW-1]}}, sum_q};
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign corr_valid = done_q;
    assign corr_data  = corr_q;
    assign est_valid  = est_v_q;
    assign est_data   = est_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_rx_zc_corr.sv
// tb/tb_rx_zc_corr.sv - randomized self-checking bench for rx_zc_corr
module tb_rx_zc_corr;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] zc_len = '0;
    logic        start = 1'b0;
    logic        ref_valid = 1'b0;
    logic [23:0] ref_data = '0;
    logic        ref_ready;
    logic        rx_valid = 1'b0;
    logic [23:0] rx_data = '0;
    logic        busy, done, est_valid, corr_valid, overflow, underflow;
    logic [31:0] est_data;
    logic [73:0] corr_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [23:0] ref_mem [64];
    logic [23:0] rx_mem  [64];
    int          est_cyc_q [$];
    logic [31:0] est_val_q [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [73:0] corr_at_done = '0;
    logic        cv_at_done = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    rx_zc_corr dut (
        .sys_clk(sys_clk), .rst(rst), .zc_len(zc_len), .start(start),
        .ref_valid(ref_valid), .ref_data(ref_data), .ref_ready(ref_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done),
        .est_valid(est_valid), .est_data(est_data), .corr_valid(corr_valid),
        .corr_data(corr_data), .overflow(overflow), .underflow(underflow)
    );

    always @(negedge sys_clk) begin
        if (est_valid) begin
            est_cyc_q.push_back(cyc);
            est_val_q.push_back(est_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            corr_at_done = corr_data;
            cv_at_done   = corr_valid;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [23:0] cpx(input int i, input int q);
        return {i[11:0], q[11:0]};
    endfunction

    function automatic int sx12(input logic [11:0] v);
        logic signed [11:0] s;
        s = v;
        return int'(s);
    endfunction

    function automatic logic [15:0] est_of(input int p);
        int e;
        e = (p + 16) >>> 5;
        if (e > 32767) e = 32767;
        else if (e < -32768) e = -32768;
        return e[15:0];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ref_ready"}, ref_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_est_valid"}, est_valid, 0);
        chk({tag, "_est_data"}, est_data, 0);
        chk({tag, "_corr_valid"}, corr_valid, 0);
        chk({tag, "_corr_i"}, corr_data[73:37], 0);
        chk({tag, "_corr_q"}, corr_data[36:0], 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            ref_mem[i] = 24'($urandom);
            rx_mem[i]  = 24'($urandom);
        end
    endtask

    task automatic fill_const(input int n, input logic [23:0] r, input logic [23:0] c);
        for (int i = 0; i < n; i++) begin
            rx_mem[i]  = r;
            ref_mem[i] = c;
        end
    endtask

    task automatic run_seq(input int len, input int nref, input bit unity,
                           input bit mid, input bit abort5, input bit uf);
        int pushed, sent, occ, s_cyc, pi, pq, ri, rq, ci, cq;
        bit mid_done, can_rx, do_rx, can_push, do_push;
        longint si, sq;
        est_cyc_q.delete();
        est_val_q.delete();
        done_cnt = 0;
        pushed = 0; sent = 0; occ = 0; mid_done = 0;
        tick;
        s_cyc  = cyc;
        start  = 1'b1;
        zc_len = 12'(len);
        if (!unity && !uf && $urandom_range(0, 1) == 1) begin
            ref_valid = 1'b1; ref_data = ref_mem[0]; pushed = 1; occ = 1;
        end
        for (int k = 0; k < 3000 && !(sent == len && pushed == nref); k++) begin
            tick;
            start = 1'b0; ref_valid = 1'b0; rx_valid = 1'b0;
            if (k == 0) chk("busy_rise", busy, 1);
            if (abort5 && sent == 5) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                check_reset("abort");
                repeat (8) tick;
                chk("abort_no_done", done_cnt, 0);
                return;
            end
            can_rx   = (sent < len) && (occ > 0) && (sent < len - 1 || pushed == nref);
            do_rx    = can_rx && (unity || $urandom_range(0, 3) != 0);
            can_push = (pushed < nref) && (occ < 16);
            do_push  = can_push && (unity || $urandom_range(0, 2) != 0);
            if (uf && cyc == s_cyc + 1) begin
                rx_valid = 1'b1; rx_data = 24'h7ff001;
            end
            if (mid && !mid_done && sent == len / 2) begin
                start = 1'b1; zc_len = 12'(len + 7); mid_done = 1'b1;
            end
            if (do_rx) begin
                rx_valid = 1'b1; rx_data = rx_mem[sent]; sent++; occ--;
            end
            if (do_push) begin
                ref_valid = 1'b1; ref_data = ref_mem[pushed]; pushed++; occ++;
            end
        end
        chk("stim_complete", (sent == len && pushed == nref), 1);
        tick;
        start = 1'b0; ref_valid = 1'b0; rx_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (done_cnt > 0) break;
        end
        chk("done_once", done_cnt, 1);
        chk("busy_fall", busy, 0);
        chk("underflow_flag", underflow, uf);
        chk("overflow_flag", overflow, 0);
        chk("est_count", est_val_q.size(), len);
        si = 0; sq = 0;
        for (int k = 0; k < len; k++) begin
            ri = sx12(rx_mem[k][23:12]);  rq = sx12(rx_mem[k][11:0]);
            ci = sx12(ref_mem[k][23:12]); cq = sx12(ref_mem[k][11:0]);
            pi = ri * ci + rq * cq;
            pq = rq * ci - ri * cq;
            si += pi;
            sq += pq;
            if (k < est_val_q.size())
                chk($sformatf("est_%0d", k), est_val_q[k], {est_of(pi), est_of(pq)});
        end
        chk("corr_valid_with_done", cv_at_done, 1);
        chk("corr_i", corr_at_done[73:37], 64'(si[36:0]));
        chk("corr_q", corr_at_done[36:0], 64'(sq[36:0]));
        if (est_cyc_q.size() > 0) begin
            chk("done_after_last_est", done_cyc - est_cyc_q[$], 1);
            if (unity) chk("first_est_latency", est_cyc_q[0] - s_cyc, 5);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        check_reset("reset");

        fill_const(12, cpx(256, 0), cpx(256, 0));
        run_seq(12, 12, 1, 0, 0, 0);
        chk("unity_est0", est_val_q.size() > 0 ? est_val_q[0] : 32'hx, {16'd2048, 16'd0});
        chk("unity_corr_i", corr_at_done[73:37], 786432);

        rx_mem[0] = cpx(0, 256); ref_mem[0] = cpx(256, 0);
        rx_mem[1] = cpx(4, 0);   ref_mem[1] = cpx(4, 0);
        rx_mem[2] = cpx(3, 0);   ref_mem[2] = cpx(5, 0);
        run_seq(3, 3, 0, 0, 0, 0);
        if (est_val_q.size() == 3) begin
            chk("conj_est", est_val_q[0], {16'd0, 16'd2048});
            chk("round_up_est", est_val_q[1], {16'd1, 16'd0});
            chk("round_down_est", est_val_q[2], {16'd0, 16'd0});
        end

        fill_const(4, cpx(-2048, -2048), cpx(-2048, -2048));
        run_seq(4, 4, 0, 0, 0, 0);
        chk("sat_est0", est_val_q.size() > 0 ? est_val_q[0] : 32'hx, {16'h7fff, 16'h0000});
        chk("sat_corr_i", corr_at_done[73:37], 4 * 8388608);

        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 40);
            fill_rand(len);
            run_seq(len, len, 0, 0, 0, 0);
        end

        fill_rand(6);
        run_seq(6, 6, 0, 0, 0, 1);

        fill_rand(10);
        run_seq(10, 10, 0, 1, 0, 0);

        fill_rand(7);
        run_seq(4, 7, 0, 0, 0, 0);
        fill_rand(5);
        run_seq(5, 5, 0, 0, 0, 0);

        tick;
        start = 1'b1; zc_len = 12'd0;
        tick;
        start = 1'b0; ref_valid = 1'b1; ref_data = cpx(1, 1);
        chk("zero_len_busy", busy, 0);
        chk("idle_ref_ready", ref_ready, 0);
        tick;
        ref_valid = 1'b0;
        chk("zero_len_busy2", busy, 0);
        chk("idle_ref_no_overflow", overflow, 0);

        tick;
        start = 1'b1; zc_len = 12'd20;
        for (int k = 0; k < 17; k++) begin
            tick;
            start = 1'b0;
            if (k == 15) chk("ref_ready_before_full", ref_ready, 1);
            if (k == 16) chk("ref_ready_full", ref_ready, 0);
            ref_valid = 1'b1; ref_data = cpx(k, -k);
        end
        tick;
        ref_valid = 1'b0;
        chk("overflow_set", overflow, 1);
        chk("overflow_no_underflow", underflow, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_reset("post_ovf_reset");

        fill_rand(12);
        run_seq(12, 12, 0, 0, 1, 0);
        fill_rand(8);
        run_seq(8, 8, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
